// File: rtl/internal_bus_arbiter_pkg.sv
// bus_arb_pkg: shared state type, requester indices and counter width for internal_bus_arbiter.
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_e;
  localparam int REQ_ADD    = 0;
  localparam int REQ_AC     = 1;
  localparam int REQ_XY     = 2;
  localparam int REQ_S      = 3;
  localparam int LOCK_CNT_W = 4;
endpackage

// File: rtl/internal_bus_arbiter_if.sv
// internal_bus_arbiter_if: SB/ADL request, lock and grant bundle between decode logic and the arbiter.
interface internal_bus_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] sb_req;
  logic [NREQ-1:0] sb_lock;
  logic [NREQ-1:0] adl_req;
  logic [NREQ-1:0] adl_lock;
  logic [NREQ-1:0] sb_gnt;
  logic [NREQ-1:0] adl_gnt;
  logic            add_sb7_en;
  logic            add_sb_60;
  logic            add_sb_7;
  logic            add_adl;
  logic            sb_busy;
  logic            adl_busy;
  modport slave (
    input  sb_req, sb_lock, adl_req, adl_lock, add_sb7_en,
    output sb_gnt, adl_gnt, add_sb_60, add_sb_7, add_adl, sb_busy, adl_busy
  );
  modport master (
    output sb_req, sb_lock, adl_req, adl_lock, add_sb7_en,
    input  sb_gnt, adl_gnt, add_sb_60, add_sb_7, add_adl, sb_busy, adl_busy
  );
endinterface

// File: rtl/internal_bus_arbiter_channel.sv
// bus_arb_channel: one bus's round-robin grant FSM with bounded lock; ARB_TURNAROUND_EN inserts an idle TURN cycle on owner change.
module bus_arb_channel
  import bus_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LOCK_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] lock_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            busy_o
);
  localparam int IW = $clog2(NREQ);
  arb_state_e            state_q;
  logic [IW-1:0]         owner_q;
  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         ptr_d;
  logic [IW-1:0]         win;
  logic [LOCK_CNT_W-1:0] lock_cnt_q;
  logic [NREQ-1:0]       gnt_q;
  logic [NREQ-1:0]       gnt_d;
  logic [NREQ-1:0]       rot;
  logic                  any;
  logic                  hold;
  int                    off;
  // Requests rotated so bit 0 is the RR pointer; the lowest set bit is the winner's offset.
  always_comb begin
    rot = NREQ'({req_i, req_i} >> ptr_q);
    off = 0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (rot[i]) off = i;
    win = IW'((int'(ptr_q) + off) % NREQ);
  end
  assign any    = |req_i;
  assign gnt_d  = NREQ'(1) << win;
  assign ptr_d  = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
  assign hold   = (state_q == GRANT) & req_i[owner_q] & lock_i[owner_q] &
                  (lock_cnt_q < LOCK_CNT_W'(LOCK_MAX));
  assign gnt_o  = gnt_q;
  assign busy_o = state_q != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
      gnt_q      <= '0;
    end else if (hold) begin
      lock_cnt_q <= lock_cnt_q + 1'b1;
    end else begin
      lock_cnt_q <= '0;
      if (!any) begin
        state_q <= IDLE;
        gnt_q   <= '0;
      end else if (state_q == GRANT && win == owner_q) begin
        state_q <= GRANT;
`ifdef ARB_TURNAROUND_EN
      end else if (state_q == GRANT) begin
        state_q <= TURN;
        gnt_q   <= '0;
`endif
      end else begin
        state_q <= GRANT;
        owner_q <= win;
        ptr_q   <= ptr_d;
        gnt_q   <= gnt_d;
      end
    end
  end
endmodule

// File: rtl/internal_bus_arbiter.sv
// internal_bus_arbiter: independent SB/ADL arbiters plus adder-hold drive decode; ARB_TURNAROUND_EN selects turnaround cycles.
module internal_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LOCK_MAX = 3
) (
  input logic                   phi_2,
  input logic                   res_n,
  internal_bus_arbiter_if.slave bus
);
  logic sb7_q;
  bus_arb_channel #(.NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) u_sb (
    .clk   (phi_2),
    .rst_n (res_n),
    .req_i (bus.sb_req),
    .lock_i(bus.sb_lock),
    .gnt_o (bus.sb_gnt),
    .busy_o(bus.sb_busy)
  );
  bus_arb_channel #(.NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) u_adl (
    .clk   (phi_2),
    .rst_n (res_n),
    .req_i (bus.adl_req),
    .lock_i(bus.adl_lock),
    .gnt_o (bus.adl_gnt),
    .busy_o(bus.adl_busy)
  );
  // Sampled every edge; only observable while the adder holds SB.
  always_ff @(posedge phi_2 or negedge res_n) begin
    if (!res_n) sb7_q <= 1'b0;
    else        sb7_q <= bus.add_sb7_en;
  end
  assign bus.add_sb_60 = bus.sb_gnt[REQ_ADD];
  assign bus.add_sb_7  = bus.sb_gnt[REQ_ADD] & sb7_q;
  assign bus.add_adl   = bus.adl_gnt[REQ_ADD];
endmodule

// File: tb/tb_internal_bus_arbiter.sv
// tb_internal_bus_arbiter: directed and random checks of internal_bus_arbiter against a behavioural model.
module tb_internal_bus_arbiter;
  localparam int NREQ     = 4;
  localparam int LOCK_MAX = 3;
`ifdef ARB_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
  localparam logic [3:0] RR_TAB [9] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
  localparam logic [3:0] LK_TAB [6] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2};
`else
  localparam bit TURN_EN = 1'b0;
  localparam logic [3:0] RR_TAB [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  localparam logic [3:0] LK_TAB [6] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h1};
`endif
  logic phi_2 = 1'b0;
  logic res_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   m_own [2];
  int   m_ptr [2];
  int   m_cnt [2];
  bit   m_turn [2];
  bit   m_sb7;
  internal_bus_arbiter_if #(.NREQ(NREQ)) ifc ();
  internal_bus_arbiter #(.NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) dut (
    .phi_2(phi_2),
    .res_n(res_n),
    .bus  (ifc)
  );
  always #5 phi_2 = ~phi_2;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction
  function automatic logic [NREQ-1:0] gmask(input int o);
    return (o < 0) ? '0 : NREQ'(1) << o;
  endfunction
  task automatic mreset();
    for (int c = 0; c < 2; c++) begin
      m_own[c] = -1; m_ptr[c] = 0; m_cnt[c] = 0; m_turn[c] = 0;
    end
    m_sb7 = 0;
  endtask
  // Owner -1 means no grant; m_turn marks the busy-but-idle turnaround cycle.
  task automatic step(input int c, input logic [NREQ-1:0] req, input logic [NREQ-1:0] lock);
    int w;
    w = pick(req, m_ptr[c]);
    m_turn[c] = 0;
    if (m_own[c] >= 0 && req[m_own[c]] && lock[m_own[c]] && m_cnt[c] < LOCK_MAX) begin
      m_cnt[c]++;
    end else begin
      m_cnt[c] = 0;
      if (w < 0) m_own[c] = -1;
      else if (w == m_own[c]) m_own[c] = w;
      else if (m_own[c] >= 0 && TURN_EN) begin
        m_own[c] = -1; m_turn[c] = 1;
      end else begin
        m_own[c] = w; m_ptr[c] = (w + 1) % NREQ;
      end
    end
  endtask
  task automatic check_all();
    logic [NREQ-1:0] es, ea;
    es = gmask(m_own[0]);
    ea = gmask(m_own[1]);
    chk("sb_gnt", ifc.sb_gnt, es);
    chk("adl_gnt", ifc.adl_gnt, ea);
    chk("add_sb_60", ifc.add_sb_60, es[0]);
    chk("add_sb_7", ifc.add_sb_7, es[0] & m_sb7);
    chk("add_adl", ifc.add_adl, ea[0]);
    chk("sb_busy", ifc.sb_busy, m_own[0] >= 0 || m_turn[0]);
    chk("adl_busy", ifc.adl_busy, m_own[1] >= 0 || m_turn[1]);
    chk("sb_onehot0", $onehot0(ifc.sb_gnt), 1);
    chk("adl_onehot0", $onehot0(ifc.adl_gnt), 1);
  endtask
  task automatic tick();
    @(posedge phi_2);
    if (!res_n) mreset();
    else begin
      step(0, ifc.sb_req, ifc.sb_lock);
      step(1, ifc.adl_req, ifc.adl_lock);
      m_sb7 = ifc.add_sb7_en;
    end
    #1 check_all();
  endtask
  task automatic drive(input logic [NREQ-1:0] sr, input logic [NREQ-1:0] sl,
                       input logic [NREQ-1:0] ar, input logic [NREQ-1:0] al, input logic s7);
    ifc.sb_req = sr; ifc.sb_lock = sl; ifc.adl_req = ar; ifc.adl_lock = al; ifc.add_sb7_en = s7;
  endtask
  task automatic pulse_reset();
    @(negedge phi_2) res_n = 1'b0;
    #1 mreset();
    check_all();
    @(negedge phi_2) res_n = 1'b1;
  endtask
  initial begin
    logic [NREQ-1:0] sr, ar;
    drive('0, '0, '0, '0, 1'b0);
    mreset();
    tick();
    tick();
    @(negedge phi_2) res_n = 1'b1;
    // Asynchronous reset while SB is granted to the adder.
    drive(4'b0001, '0, '0, '0, 1'b0);
    tick();
    tick();
    chk("hold_gnt", ifc.sb_gnt, 4'b0001);
    #2 res_n = 1'b0;
    #1 mreset();
    chk("arst_sb_gnt", ifc.sb_gnt, 0);
    chk("arst_add_sb_60", ifc.add_sb_60, 0);
    chk("arst_sb_busy", ifc.sb_busy, 0);
    @(negedge phi_2) res_n = 1'b1;
    drive(4'hf, '0, '0, '0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rr_seq", ifc.sb_gnt, RR_TAB[i]);
    end
    pulse_reset();
    drive(4'b0011, 4'b0001, '0, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("lock_seq", ifc.sb_gnt, LK_TAB[i]);
    end
    pulse_reset();
    drive(4'b0001, '0, '0, '0, 1'b0);
    tick();
    chk("split_60", ifc.add_sb_60, 1);
    chk("split_7_off", ifc.add_sb_7, 0);
    drive(4'b0001, '0, '0, '0, 1'b1);
    tick();
    chk("split_7_on", ifc.add_sb_7, 1);
    pulse_reset();
    drive(4'b0001, '0, 4'b0001, '0, 1'b1);
    tick();
    chk("indep_sb", ifc.add_sb_60, 1);
    chk("indep_adl", ifc.add_adl, 1);
    drive(4'b0001, '0, 4'b0010, '0, 1'b1);
    tick();
    chk("indep_adl_drop", ifc.add_adl, 0);
    chk("indep_sb_keep", ifc.add_sb_60, 1);
    tick();
    chk("indep_adl_new", ifc.adl_gnt, 4'b0010);
    pulse_reset();
    drive(4'b0001, '0, '0, '0, 1'b0);
    tick();
    drive(4'b0010, '0, '0, '0, 1'b0);
    tick();
    chk("switch", ifc.sb_gnt, TURN_EN ? 4'h0 : 4'h2);
    sr = '0;
    ar = '0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 9) < 3) sr = NREQ'($urandom);
      if ($urandom_range(0, 9) < 3) ar = NREQ'($urandom);
      drive(sr, sr & NREQ'($urandom), ar, ar & NREQ'($urandom), 1'($urandom));
      tick();
      if ($urandom_range(0, 199) == 0) begin
        #2 res_n = 1'b0;
        #1 mreset();
        check_all();
        #1 res_n = 1'b1;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/internal_bus_arbiter.md
# internal_bus_arbiter

Arbitrates the internal SB and ADL buses between up to NREQ tri-state drivers, the adder hold register among them, and produces their drive enables. Each bus has an independent round-robin grant state machine with optional lock and a turnaround cycle on owner change, so no two drivers ever enable onto the same bus in the same cycle. Sits between the decode/timing logic, which raises requests, and the register-file drivers, which consume grants. Requester index 0 is the adder hold register; its grants are decoded directly into add_adl, add_sb_60 and add_sb_7.

## Interface
- NREQ, 4, number of requesters per bus (2..8); index 0 is the adder hold register.
- LOCK_MAX, 3, maximum consecutive locked cycles before a forced release (1..15).

- phi_2  in  1  clock; all state updates on rising edge.
- res_n  in  1  reset, asynchronous, active-low.
- sb_req  in  NREQ  SB drive request per requester.
- sb_lock  in  NREQ  current SB owner asks to keep the bus next cycle.
- adl_req  in  NREQ  ADL drive request per requester.
- adl_lock  in  NREQ  current ADL owner asks to keep the bus next cycle.
- add_sb7_en  in  1  when the adder owns SB, the adder also drives bit 7.
- sb_gnt  out  NREQ  one-hot-or-zero SB grant, registered.
- adl_gnt  out  NREQ  one-hot-or-zero ADL grant, registered.
- add_sb_60  out  1  equals sb_gnt[0].
- add_sb_7  out  1  sb_gnt[0] and registered add_sb7_en.
- add_adl  out  1  equals adl_gnt[0].
- sb_busy, adl_busy  out  1  bus state is not IDLE.

## Operation
- Two identical, independent bus channels (SB, ADL). Each has state {IDLE, GRANT, TURN}, an owner index, an RR pointer and a lock counter (4 bits).
- Winner: the first requester at or after the RR pointer, wrapping modulo NREQ. After each new grant the pointer becomes owner+1 (wrapping NREQ-1 to 0).
- IDLE: if any req, go to GRANT with the winner; otherwise stay. All grants 0.
- GRANT: the owner's grant bit is asserted.
  - Owner req and lock, with lock_cnt < LOCK_MAX: stay; lock_cnt++.
  - Otherwise lock_cnt is cleared, then:
    - Winner equals the owner: stay, no turnaround.
    - Winner differs: go to TURN.
    - No req: go to IDLE.
- Lock counter: LOCK_MAX reached with lock still high forces re-arbitration. The owner can win again only if it is the sole requester.
- TURN: all grants 0 for one cycle. At the end of TURN, the winner is evaluated from the requests present then: GRANT to the winner, or IDLE if none.
- Grants are always one-hot or zero. Lock from a non-owner is ignored.
- add_sb7_en is sampled on the same edge that asserts or keeps sb_gnt[0]. add_sb_7 is never 1 while add_sb_60 is 0.
- Simultaneous events: SB and ADL arbitrate independently, so the adder may own both buses at once. Request withdrawal takes effect at the next edge.

## Timing
- Latency: a request sampled at edge n gives a grant visible after edge n (IDLE to GRANT).
- Owner change: grant drops after edge n, new grant after edge n+1 (one TURN cycle).
- Reset, at any time including mid-grant or mid-TURN: state IDLE, all grants and add_* outputs 0, busy 0, pointers 0, lock counters 0, registered add_sb7_en 0.
- Reset deassertion is synchronized by the caller. The first arbitration happens at the first rising edge with res_n high.

## Configuration
- ARB_TURNAROUND_EN defined: behaviour exactly as above, with a one-cycle TURN on every owner change.
- Not defined: TURN is unreachable. GRANT passes directly to the new winner at the same edge, so the old grant drops and the new grant rises together. The rest is unchanged.

## Structure
- Package bus_arb_pkg holds:
  - the state enum (IDLE, GRANT, TURN);
  - requester index constants: REQ_ADD=0, REQ_AC=1, REQ_XY=2, REQ_S=3;
  - LOCK_CNT_W=4.
- Sub-module bus_arb_channel holds one bus's FSM, RR pointer and lock counter. It is instantiated twice (SB, ADL). The top level adds the add_* decode and the add_sb7_en register.

## Test plan
- Reset mid-GRANT: sb_req=0001 and grant held, then res_n pulsed low between edges -> sb_gnt=0000 and add_sb_60=0 immediately (asynchronous), state IDLE.
- Round-robin: sb_req=1111 held, no lock (define set) -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- Lock limit: sb_req=0011, sb_lock=0001, LOCK_MAX=3 -> sb_gnt=0001 for 4 cycles, then 0000, then 0010.
- Adder split: sb_req[0]=1 with add_sb7_en=0 -> add_sb_60=1, add_sb_7=0; add_sb7_en=1 the next cycle -> add_sb_7=1 one edge later.
- Independence: sb_req=0001 and adl_req=0001 together -> add_sb_60=1 and add_adl=1 in the same cycle; adl_req changed to 0010 -> add_adl=0 (TURN), then adl_gnt=0010, while add_sb_60 is unaffected.
- Define not set: sb_req changes from 0001 to 0010 -> sb_gnt goes 0001 to 0010 at one edge with no zero cycle, and is never two-hot.
